// File: rtl/morse_letter_scheduler_pkg.sv
// Shared types for the Morse letter scheduler: FSM states and the letter-pattern table.
// Patterns are left-aligned so bit PAT_W-1 is the first symbol sent.
package morse_pkg;

    localparam int PAT_W = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [PAT_W-1:0] pattern_of(input logic [2:0] code);
        logic [PAT_W-1:0] pat;
        case (code)
            3'd0:    pat = 14'b10101000000000;
            3'd1:    pat = 14'b11100000000000;
            3'd2:    pat = 14'b10101110000000;
            3'd3:    pat = 14'b10101011100000;
            3'd4:    pat = 14'b10111011100000;
            3'd5:    pat = 14'b11101010111000;
            3'd6:    pat = 14'b11101011101110;
            default: pat = 14'b11101110101000;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/morse_letter_scheduler_if.sv
// Requester-side bundle of the Morse letter scheduler.
// The master is the letter-source side; the slave is the scheduler.
interface morse_letter_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [3*NUM_REQ-1:0] letter_sel;
    logic                 abort;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [ID_W-1:0]      active_id;
    logic                 light_out;

    modport master (
        output req, letter_sel, abort,
        input  grant, done, busy, active_id, light_out
    );

    modport slave (
        input  req, letter_sel, abort,
        output grant, done, busy, active_id, light_out
    );

endinterface

// File: rtl/morse_letter_scheduler_tick_gen.sv
// Symbol-tick generator: a TICK_DIV-cycle down-counter that restarts on demand
// and pulses tick on the last cycle of each symbol period.
module morse_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (restart) begin
            tick_cnt <= RELOAD;
        end else if (enable) begin
            tick_cnt <= (tick_cnt == '0) ? RELOAD : tick_cnt - 1'b1;
        end
    end

    assign tick = enable && !restart && (tick_cnt == '0);

endmodule

// File: rtl/morse_letter_scheduler.sv
// Round-robin owner of one Morse light: grants a requester, shifts its letter
// pattern out one bit per symbol tick, then holds the light dark for the gap.
module morse_letter_scheduler
    import morse_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PATTERN_W = PAT_W,
    parameter int TICK_DIV  = 12_500_000,
    parameter int GAP_TICKS = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    morse_letter_scheduler_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int BIT_W = $clog2(PATTERN_W);
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    state_t               state, state_d;
    logic                 tick, found, start, busy;
    logic [ID_W-1:0]      pick, rr_ptr, active_id;
    logic [PATTERN_W-1:0] shreg, pattern;
    logic [BIT_W-1:0]     bit_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [NUM_REQ-1:0]   grant, grant_d, done, done_d;
    logic                 light, light_d;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    assign start   = (state == IDLE) && found;
    assign pattern = pattern_of(bus.letter_sel[3*int'(pick) +: 3]);

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (start),
        .enable  (busy),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (found) state_d = SHIFT;
            SHIFT:   if (bus.abort) state_d = IDLE;
                     else if (tick && bit_cnt == '0) state_d = GAP;
            GAP:     if (bus.abort) state_d = IDLE;
                     else if (tick && gap_cnt == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        grant_d = '0;
        done_d  = '0;
        light_d = 1'b0;
        case (state)
            IDLE: if (found) begin
                grant_d[pick] = 1'b1;
                light_d       = pattern[PATTERN_W-1];
            end
            SHIFT: if (!bus.abort) begin
                if (!tick)               light_d = shreg[PATTERN_W-1];
                else if (bit_cnt != '0)  light_d = shreg[PATTERN_W-2];
            end
            GAP: if (!bus.abort && tick && gap_cnt == '0) done_d[active_id] = 1'b1;
            default: ;
        endcase
    end

    // Grant/done/light are registered so the board sees glitch-free outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            active_id <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            done      <= '0;
            light     <= 1'b0;
        end else begin
            grant <= grant_d;
            done  <= done_d;
            light <= light_d;
            case (state)
                IDLE: if (found) begin
                    active_id <= pick;
                    rr_ptr    <= (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                    shreg     <= pattern;
                    bit_cnt   <= BIT_W'(PATTERN_W - 1);
                end
                SHIFT: if (!bus.abort && tick) begin
                    shreg <= shreg << 1;
                    if (bit_cnt == '0) gap_cnt <= GAP_W'(GAP_TICKS - 1);
                    else               bit_cnt <= bit_cnt - 1'b1;
                end
                GAP: if (!bus.abort && tick && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.grant     = grant;
    assign bus.done      = done;
    assign bus.busy      = busy;
    assign bus.active_id = active_id;
    assign bus.light_out = light;

endmodule

// File: tb/tb_morse_letter_scheduler.sv
// Directed plus randomized bench for morse_letter_scheduler (TICK_DIV=4, GAP_TICKS=3),
// checked against a per-cycle expected light waveform built from the letter table.
module tb_morse_letter_scheduler;

    localparam int N    = 4;
    localparam int TD   = 4;
    localparam int GAPT = 3;
    localparam int PW   = 14;
    localparam int LEN  = (PW + GAPT) * TD;

    logic clock;
    logic reset;
    int   tests;
    int   fails;
    int   exp_ptr;

    logic [PW-1:0] pats [8] = '{
        14'b10101000000000, 14'b11100000000000, 14'b10101110000000, 14'b10101011100000,
        14'b10111011100000, 14'b11101010111000, 14'b11101011101110, 14'b11101110101000
    };

    morse_letter_scheduler_if #(.NUM_REQ(N)) bus ();

    morse_letter_scheduler #(
        .NUM_REQ(N), .PATTERN_W(PW), .TICK_DIV(TD), .GAP_TICKS(GAPT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_choose(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic set_sel(input int i, input int code);
        bus.letter_sel[3*i +: 3] = 3'(code);
    endtask

    // Raise req and wait (bounded) for the grant; leaves the bench at the grant's negedge.
    task automatic get_grant(input logic [N-1:0] r, output int id, output int waited);
        int exp_id;
        bus.req = r;
        exp_id  = rr_choose(r, exp_ptr);
        waited  = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            waited = k;
            if (bus.grant != '0) break;
        end
        chk("grant", 32'(bus.grant), 32'(1 << exp_id));
        chk("active_id", 32'(bus.active_id), 32'(exp_id));
        exp_ptr = (exp_id + 1) % N;
        id = exp_id;
    endtask

    // Follow one letter cycle by cycle from the grant negedge (c=0).
    task automatic follow(input int id, input int code, input int abort_at, input int new_sel);
        logic exp_light;
        for (int c = 0; c <= LEN; c++) begin
            if (c > 0) @(negedge clock);
            if (abort_at >= 0 && c == abort_at + 1) begin
                bus.abort = 1'b0;
                chk("abort_light", 32'(bus.light_out), 32'd0);
                chk("abort_busy", 32'(bus.busy), 32'd0);
                chk("abort_done", 32'(bus.done), 32'd0);
                for (int k = 0; k < 60; k++) begin
                    @(negedge clock);
                    chk("post_abort_done", 32'(bus.done), 32'd0);
                end
                return;
            end
            exp_light = (c < PW * TD) ? pats[code][PW - 1 - c / TD] : 1'b0;
            chk("light", 32'(bus.light_out), 32'(exp_light));
            chk("busy", 32'(bus.busy), (c < LEN) ? 32'd1 : 32'd0);
            chk("done", 32'(bus.done), (c == LEN) ? 32'(1 << id) : 32'd0);
            if (c > 0) chk("grant_pulse", 32'(bus.grant), 32'd0);
            chk("active_hold", 32'(bus.active_id), 32'(id));
            if (c == 1 && new_sel >= 0) set_sel(id, new_sel);
            if (c == abort_at) bus.abort = 1'b1;
        end
    endtask

    initial begin
        int id, waited, base;
        int codes [N];
        logic [N-1:0] r;
        tests = 0;
        fails = 0;
        exp_ptr = 0;
        bus.req = '0;
        bus.letter_sel = '0;
        bus.abort = 1'b0;
        reset = 1'b0;
        #12;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_light", 32'(bus.light_out), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Reset mid-letter on requester 2 with a letter that starts lit.
        set_sel(2, 1);
        get_grant(4'b0100, id, waited);
        bus.req = '0;
        repeat (5) @(negedge clock);
        chk("pre_rst_light", 32'(bus.light_out), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_grant", 32'(bus.grant), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_id", 32'(bus.active_id), 32'd0);
        chk("arst_light", 32'(bus.light_out), 32'd0);
        exp_ptr = 0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("idle_grant", 32'(bus.grant), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end

        // Pointer must have been cleared: 1100 goes to 2.
        set_sel(2, 4);
        get_grant(4'b1100, id, waited);
        bus.req = '0;
        follow(id, 4, -1, -1);

        // Single requester, code 0.
        set_sel(0, 0);
        get_grant(4'b0001, id, waited);
        bus.req = '0;
        follow(id, 0, -1, -1);

        // All requesting: 1,2,3,0,1 after the previous grant to 0.
        base = int'($urandom_range(0, 7));
        for (int i = 0; i < N; i++) begin
            codes[i] = (base + i) % 8;
            set_sel(i, codes[i]);
        end
        for (int n = 0; n < 5; n++) begin
            get_grant(4'b1111, id, waited);
            if (n > 0) chk("one_idle_cycle", 32'(waited), 32'd1);
            if (n == 4) bus.req = '0;
            follow(id, codes[id], -1, -1);
        end

        // Grant to 2, then 0011 wraps from 3 to 0.
        get_grant(4'b0100, id, waited);
        bus.req = '0;
        follow(id, codes[id], -1, -1);
        get_grant(4'b0011, id, waited);
        chk("wrap_pick", 32'(id), 32'd0);
        bus.req = '0;
        follow(id, codes[id], -1, -1);

        // Abort during bit 5, then round robin resumes after the aborted owner.
        get_grant(4'b0010, id, waited);
        bus.req = '0;
        follow(id, codes[id], 5 * TD + 1, -1);
        get_grant(4'b1111, id, waited);
        bus.req = '0;
        // Abort lands on the final gap tick; letter_sel also changes mid-letter.
        follow(id, codes[id], LEN - 1, (codes[id] + 3) % 8);
        set_sel(id, codes[id]);

        // Randomized masks and letters.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < N; i++) begin
                codes[i] = int'($urandom_range(0, 7));
                set_sel(i, codes[i]);
            end
            r = 4'($urandom_range(1, 15));
            get_grant(r, id, waited);
            bus.req = '0;
            follow(id, codes[id], -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
